// File: rtl/dcache_pkg.sv
// Shared configuration, derived address-field widths, FSM state and memory
// request type for the direct-mapped write-through L1 data cache.
package dcache_pkg;

   localparam int DC_DATA_W         = 32;
   localparam int DC_ADDR_W         = 32;
   localparam int DC_NUM_SETS       = 64;
   localparam int DC_WORDS_PER_LINE = 4;

   // Address split: | tag | set index | word index | byte offset |
   localparam int OFFSET_W   = 2;
   localparam int WORD_IDX_W = $clog2(DC_WORDS_PER_LINE);
   localparam int SET_W      = $clog2(DC_NUM_SETS);
   localparam int TAG_W      = DC_ADDR_W - SET_W - WORD_IDX_W - OFFSET_W;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REFILL = 2'd1,
      WRITE  = 2'd2
   } dcache_state_t;

   // A store request as presented to main memory; held in WRITE until accepted.
   typedef struct packed {
      logic                   write;
      logic [DC_ADDR_W-1:0]   addr;
      logic [DC_DATA_W-1:0]   wdata;
      logic [DC_DATA_W/8-1:0] byte_en;
   } mem_req_t;

endpackage

// File: rtl/dcache_array.sv
// Tag, valid and data storage for the data cache. Reads are combinational;
// data words are written with byte enables (store hits and refill beats use
// the same port) and a line is validated by writing its tag.
module dcache_array
   import dcache_pkg::*;
#(
   parameter int  NUM_SETS       = DC_NUM_SETS,
   parameter int  WORDS_PER_LINE = DC_WORDS_PER_LINE,
   parameter int  DATA_WIDTH     = DC_DATA_W,
   parameter int  TAG_WIDTH      = TAG_W,
   localparam int SET_BITS       = $clog2(NUM_SETS),
   localparam int WORD_BITS      = $clog2(WORDS_PER_LINE),
   localparam int BE_W           = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [SET_BITS-1:0]   rd_set,
   input  logic [WORD_BITS-1:0]  rd_word,
   output logic                  rd_valid,
   output logic [TAG_WIDTH-1:0]  rd_tag,
   output logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  wr_en,
   input  logic [SET_BITS-1:0]   wr_set,
   input  logic [WORD_BITS-1:0]  wr_word,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [BE_W-1:0]       wr_be,
   input  logic                  tag_wr_en,
   input  logic [SET_BITS-1:0]   tag_wr_set,
   input  logic [TAG_WIDTH-1:0]  tag_wr_tag
);

   logic [NUM_SETS-1:0]             valid_r;
   logic [TAG_WIDTH-1:0]            tag_r  [NUM_SETS];
   logic [DATA_WIDTH-1:0]           data_r [NUM_SETS*WORDS_PER_LINE];
   logic [SET_BITS+WORD_BITS-1:0]   rd_idx_s;
   logic [SET_BITS+WORD_BITS-1:0]   wr_idx_s;

   assign rd_idx_s = {rd_set, rd_word};
   assign wr_idx_s = {wr_set, wr_word};
   assign rd_valid = valid_r[rd_set];
   assign rd_tag   = tag_r[rd_set];
   assign rd_data  = data_r[rd_idx_s];

   // Valid bits: cleared by reset, set when a completed refill writes the tag.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_r <= '0;
      end else if (tag_wr_en) begin
         valid_r[tag_wr_set] <= 1'b1;
      end
   end

   // Tag storage: written together with the valid bit at the end of a refill.
   always_ff @(posedge clk) begin
      if (tag_wr_en) begin
         tag_r[tag_wr_set] <= tag_wr_tag;
      end
   end

   // Data storage: byte-enable word write shared by store hits and refill beats.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < BE_W; b++) begin
            if (wr_be[b]) begin
               data_r[wr_idx_s][8*b +: 8] <= wr_data[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache for the
// M stage. Loads hit with zero added latency; misses refill a whole line
// through a valid/ready request channel with in-order read responses.
// Optional build macro DCACHE_STATS_EN adds hit_count / miss_count outputs.
module data_cache
   import dcache_pkg::*;
#(
   parameter int DATA_WIDTH     = DC_DATA_W,
   parameter int ADDR_WIDTH     = DC_ADDR_W,
   parameter int NUM_SETS       = DC_NUM_SETS,
   parameter int WORDS_PER_LINE = DC_WORDS_PER_LINE
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   input  logic                    req_write,
   input  logic [ADDR_WIDTH-1:0]   addr,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] byte_en,
   output logic [DATA_WIDTH-1:0]   rdata,
   output logic                    cache_stall,
   output logic                    mem_req_valid,
   output logic                    mem_req_write,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   output logic [DATA_WIDTH/8-1:0] mem_byte_en,
   input  logic                    mem_req_ready,
   input  logic                    mem_rvalid,
`ifdef DCACHE_STATS_EN
   output logic [31:0]             hit_count,
   output logic [31:0]             miss_count,
`endif
   input  logic [DATA_WIDTH-1:0]   mem_rdata
);

   localparam int BE_W      = DATA_WIDTH / 8;
   localparam int WORD_BITS = $clog2(WORDS_PER_LINE);
   localparam int SET_BITS  = $clog2(NUM_SETS);
   localparam int LINE_LSB  = OFFSET_W + WORD_BITS;
   localparam int TAG_BITS  = ADDR_WIDTH - SET_BITS - LINE_LSB;
   localparam int LINE_W    = ADDR_WIDTH - LINE_LSB;
   localparam logic [WORD_BITS:0]   LINE_WORDS = (WORD_BITS+1)'(WORDS_PER_LINE);
   localparam logic [WORD_BITS-1:0] LAST_BEAT  = WORD_BITS'(WORDS_PER_LINE - 1);

   dcache_state_t             state_r, state_n;
   logic [WORD_BITS:0]        issue_cnt_r;
   logic [WORD_BITS-1:0]      beat_cnt_r;
   logic [DATA_WIDTH-1:0]     rdata_r;
   logic [LINE_W-1:0]         line_r;
   mem_req_t                  wr_req_r;

   logic [TAG_BITS-1:0]       tag_s;
   logic [SET_BITS-1:0]       set_s;
   logic [WORD_BITS-1:0]      word_s;
   logic [ADDR_WIDTH-1:0]     word_addr_s;
   logic [SET_BITS-1:0]       refill_set_s;
   logic [TAG_BITS-1:0]       refill_tag_s;
   logic                      addr_unused_s;

   logic                      rd_valid_s;
   logic [TAG_BITS-1:0]       rd_tag_s;
   logic [DATA_WIDTH-1:0]     rd_data_s;
   logic                      hit_s;

   logic                      arr_wr_en_s;
   logic [SET_BITS-1:0]       arr_wr_set_s;
   logic [WORD_BITS-1:0]      arr_wr_word_s;
   logic [DATA_WIDTH-1:0]     arr_wr_data_s;
   logic [BE_W-1:0]           arr_wr_be_s;
   logic                      tag_wr_en_s;

   assign tag_s         = addr[ADDR_WIDTH-1 -: TAG_BITS];
   assign set_s         = addr[LINE_LSB +: SET_BITS];
   assign word_s        = addr[OFFSET_W +: WORD_BITS];
   assign word_addr_s   = {addr[ADDR_WIDTH-1:OFFSET_W], {OFFSET_W{1'b0}}};
   assign refill_set_s  = line_r[SET_BITS-1:0];
   assign refill_tag_s  = line_r[LINE_W-1 -: TAG_BITS];
   assign addr_unused_s = ^addr[OFFSET_W-1:0];
   assign hit_s         = rd_valid_s && (rd_tag_s == tag_s);

   dcache_array #(
      .NUM_SETS       (NUM_SETS),
      .WORDS_PER_LINE (WORDS_PER_LINE),
      .DATA_WIDTH     (DATA_WIDTH),
      .TAG_WIDTH      (TAG_BITS)
   ) u_array (
      .clk        (clk),
      .rst        (rst),
      .rd_set     (set_s),
      .rd_word    (word_s),
      .rd_valid   (rd_valid_s),
      .rd_tag     (rd_tag_s),
      .rd_data    (rd_data_s),
      .wr_en      (arr_wr_en_s),
      .wr_set     (arr_wr_set_s),
      .wr_word    (arr_wr_word_s),
      .wr_data    (arr_wr_data_s),
      .wr_be      (arr_wr_be_s),
      .tag_wr_en  (tag_wr_en_s),
      .tag_wr_set (refill_set_s),
      .tag_wr_tag (refill_tag_s)
   );

   // Next state, stall, memory request and array write control.
   always_comb begin
      state_n       = state_r;
      rdata         = rdata_r;
      cache_stall   = 1'b0;
      mem_req_valid = 1'b0;
      mem_req_write = 1'b0;
      mem_addr      = '0;
      mem_wdata     = '0;
      mem_byte_en   = '0;
      arr_wr_en_s   = 1'b0;
      arr_wr_set_s  = set_s;
      arr_wr_word_s = word_s;
      arr_wr_data_s = wdata;
      arr_wr_be_s   = byte_en;
      tag_wr_en_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (req_valid && !req_write) begin
               if (hit_s) begin
                  rdata = rd_data_s;
               end else begin
                  cache_stall = 1'b1;
                  state_n     = REFILL;
               end
            end else if (req_valid && req_write) begin
               // Write-through: always forward; update the cached copy only on a hit.
               mem_req_valid = 1'b1;
               mem_req_write = 1'b1;
               mem_addr      = word_addr_s;
               mem_wdata     = wdata;
               mem_byte_en   = byte_en;
               arr_wr_en_s   = hit_s;
               if (mem_req_ready) begin
                  state_n = IDLE;
               end else begin
                  cache_stall = 1'b1;
                  state_n     = WRITE;
               end
            end else begin
               state_n = IDLE;
            end
         end
         REFILL: begin
            cache_stall = 1'b1;
            if (issue_cnt_r < LINE_WORDS) begin
               mem_req_valid = 1'b1;
               mem_addr      = {line_r, issue_cnt_r[WORD_BITS-1:0], {OFFSET_W{1'b0}}};
            end else begin
               mem_req_valid = 1'b0;
            end
            if (mem_rvalid) begin
               arr_wr_en_s   = 1'b1;
               arr_wr_set_s  = refill_set_s;
               arr_wr_word_s = beat_cnt_r;
               arr_wr_data_s = mem_rdata;
               arr_wr_be_s   = '1;
               if (beat_cnt_r == LAST_BEAT) begin
                  tag_wr_en_s = 1'b1;
                  state_n     = IDLE;
               end else begin
                  state_n = REFILL;
               end
            end else begin
               state_n = REFILL;
            end
         end
         WRITE: begin
            // The hit update already happened in IDLE; only the memory write is pending.
            mem_req_valid = 1'b1;
            mem_req_write = wr_req_r.write;
            mem_addr      = wr_req_r.addr;
            mem_wdata     = wr_req_r.wdata;
            mem_byte_en   = wr_req_r.byte_en;
            if (mem_req_ready) begin
               state_n = IDLE;
            end else begin
               cache_stall = 1'b1;
               state_n     = WRITE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // State, held load data, refill counters and captured request.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         issue_cnt_r <= '0;
         beat_cnt_r  <= '0;
         rdata_r     <= '0;
         line_r      <= '0;
         wr_req_r    <= '0;
      end else begin
         state_r <= state_n;
         rdata_r <= rdata;
         if ((state_r == REFILL) && (state_n == REFILL)) begin
            if (mem_req_valid && mem_req_ready) begin
               issue_cnt_r <= issue_cnt_r + (WORD_BITS+1)'(1'b1);
            end
            if (mem_rvalid) begin
               beat_cnt_r <= beat_cnt_r + WORD_BITS'(1'b1);
            end
         end else begin
            issue_cnt_r <= '0;
            beat_cnt_r  <= '0;
         end
         if ((state_r == IDLE) && req_valid) begin
            line_r   <= addr[ADDR_WIDTH-1:LINE_LSB];
            wr_req_r <= '{write: 1'b1, addr: word_addr_s, wdata: wdata, byte_en: byte_en};
         end
      end
   end

`ifdef DCACHE_STATS_EN
   logic stat_hit_s;
   logic stat_miss_s;

   assign stat_hit_s  = (state_r == IDLE) && req_valid && !req_write && hit_s;
   assign stat_miss_s = (state_r == IDLE) && req_valid && !req_write && !hit_s;

   // Count IDLE-state load decisions; the post-refill replay lands as a hit.
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_count  <= 32'd0;
         miss_count <= 32'd0;
      end else begin
         if (stat_hit_s) begin
            hit_count <= hit_count + 32'd1;
         end
         if (stat_miss_s) begin
            miss_count <= miss_count + 32'd1;
         end
      end
   end
`endif

endmodule
